// File: rtl/see_source_if.sv
// Ready/valid channel carrying one data word per accepted beat.
//
// Handshake: the source raises vld together with a stable data word; a beat
// transfers on every rising clock edge where vld && rdy. Once vld is high it
// stays high, and data stays unchanged, until that transfer happens. vld
// never depends combinationally on rdy.
interface rdy_vld_if #(
    parameter int DATA_W = 32
);
    logic              vld;
    logic              rdy;
    logic [DATA_W-1:0] data;

    modport src (output vld, output data, input rdy);
    modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/see_source.sv
// see_source: producer of a programmable burst of incrementing data words on
// a ready/valid channel, with an optional fixed idle gap after each beat.
module see_source #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  start_count,
    input  logic [DATA_W-1:0] start_base,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg,
    rdy_vld_if.src            see
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  remaining_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        gap_cnt_q;
    logic              vld_q;
    logic              busy_q;
    logic              done_q;
    logic              xfer;

    // A beat moves only while presenting it; vld is high exactly in SEND.
    assign xfer = (state == SEND) && see.rdy;

    assign see.vld   = vld_q;
    assign see.data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state selection: start only matters in IDLE, FIN always lasts one cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (start_count != '0) ? SEND : FIN;
                end
            end
            SEND: begin
                if (see.rdy) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_n = FIN;
                    end else if (GAP > 0) begin
                        state_n = WAIT;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            WAIT: begin
                if (gap_cnt_q <= 4'd1) begin
                    state_n = SEND;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are flopped from the next state so nothing reaches a port combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            vld_q  <= (state_n == SEND);
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == FIN);
        end
    end

    // Burst bookkeeping: latch on start, advance on each transfer, count down the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            data_q      <= '0;
            gap_cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (start_count != '0)) begin
                        remaining_q <= start_count;
                        data_q      <= start_base;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        data_q      <= data_q + DATA_W'(1);
                        if (GAP > 0) begin
                            gap_cnt_q <= 4'(GAP);
                        end
                    end
                end
                WAIT: begin
                    gap_cnt_q <= gap_cnt_q - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_see_source.sv
// Bench for see_source: instance 0 runs with no gap, instance 1 with a gap of
// three cycles. A cycle-level behavioural model predicts every output and a
// scoreboard holds the hand-computed data words each burst must deliver.
module tb_see_source;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start = 2'b00;
    logic [1:0] rdy = 2'b00;
    logic [15:0] cnt0 = '0, cnt1 = '0;
    logic [31:0] base0 = '0, base1 = '0;

    wire [1:0] busy_o;
    wire [1:0] done_o;
    wire [1:0] vld_o;
    wire [1:0] st0, st1;
    logic [31:0] data_o [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rdy_vld_if #(.DATA_W(32)) see0 ();
    rdy_vld_if #(.DATA_W(32)) see1 ();

    assign see0.rdy = rdy[0];
    assign see1.rdy = rdy[1];
    assign vld_o = {see1.vld, see0.vld};
    assign data_o[0] = see0.data;
    assign data_o[1] = see1.data;

    see_source #(.DATA_W(32), .CNT_W(16), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .start_count(cnt0),
        .start_base(base0), .busy(busy_o[0]), .done(done_o[0]),
        .state_dbg(st0), .see(see0)
    );

    see_source #(.DATA_W(32), .CNT_W(16), .GAP(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .start_count(cnt1),
        .start_base(base1), .busy(busy_o[1]), .done(done_o[1]),
        .state_dbg(st1), .see(see1)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A burst is "active" while beats remain; cool counts idle cycles still
    // owed after a beat; fin marks the single completion cycle.
    bit          m_act [2];
    bit          m_fin [2];
    int          m_left [2];
    int          m_cool [2];
    logic [31:0] m_data [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i]  <= 1'b0;
                m_fin[i]  <= 1'b0;
                m_left[i] <= 0;
                m_cool[i] <= 0;
                m_data[i] <= '0;
            end else if (m_fin[i]) begin
                m_fin[i] <= 1'b0;
            end else if (!m_act[i]) begin
                if (start[i]) begin
                    if (((i == 0) ? cnt0 : cnt1) == 16'd0) begin
                        m_fin[i] <= 1'b1;
                    end else begin
                        m_act[i]  <= 1'b1;
                        m_left[i] <= int'((i == 0) ? cnt0 : cnt1);
                        m_data[i] <= (i == 0) ? base0 : base1;
                        m_cool[i] <= 0;
                    end
                end
            end else if (m_cool[i] > 0) begin
                m_cool[i] <= m_cool[i] - 1;
            end else if (rdy[i]) begin
                m_data[i] <= m_data[i] + 32'd1;
                if (m_left[i] == 1) begin
                    m_act[i] <= 1'b0;
                    m_fin[i] <= 1'b1;
                end else begin
                    m_left[i] <= m_left[i] - 1;
                    m_cool[i] <= gap_of(i);
                end
            end
        end
    end

    // ---------------- scoreboard and per-cycle compare ----------------
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int xc0[$];
    int xc1[$];
    int busy_cnt [2] = '{0, 0};
    int last_done [2] = '{-1, -1};
    bit pv [2] = '{0, 0};
    bit pr [2] = '{0, 0};
    logic [31:0] pd [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("vld%0d", i), {31'd0, vld_o[i]}, {31'd0, m_act[i] && (m_cool[i] == 0)});
            chk($sformatf("busy%0d", i), {31'd0, busy_o[i]}, {31'd0, m_act[i] || m_fin[i]});
            chk($sformatf("done%0d", i), {31'd0, done_o[i]}, {31'd0, m_fin[i]});
            chk($sformatf("data%0d", i), data_o[i], m_data[i]);
            if (!rst_n) begin
                pv[i] = 1'b0;
            end else begin
                if (pv[i] && !pr[i]) begin
                    chk($sformatf("hold_vld%0d", i), {31'd0, vld_o[i]}, 32'd1);
                    chk($sformatf("hold_data%0d", i), data_o[i], pd[i]);
                end
                pv[i] = vld_o[i];
                pr[i] = rdy[i];
                pd[i] = data_o[i];
                if (vld_o[i] && rdy[i]) begin
                    if (i == 0) begin
                        xc0.push_back(cyc);
                        if (exp_q0.size() == 0) chk("extra_beat0", data_o[0], 32'hdead_beef);
                        else chk("beat0", data_o[0], exp_q0.pop_front());
                    end else begin
                        xc1.push_back(cyc);
                        if (exp_q1.size() == 0) chk("extra_beat1", data_o[1], 32'hdead_beef);
                        else chk("beat1", data_o[1], exp_q1.pop_front());
                    end
                end
                if (busy_o[i]) busy_cnt[i]++;
                if (done_o[i]) last_done[i] = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int i, input logic [15:0] c, input logic [31:0] b);
        if (i == 0) begin cnt0 = c; base0 = b; end
        else begin cnt1 = c; base1 = b; end
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, input bit rnd);
        int n = 0;
        while (busy_o[i] && n < budget) begin
            if (rnd) rdy[i] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk($sformatf("idle_timeout%0d", i), {31'd0, busy_o[i]}, 32'd0);
    endtask

    // ---------------- directed test sequence ----------------
    int t0;
    int d_before;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", {31'd0, see0.vld}, 32'd0);
        chk("rst_data", see0.data, 32'd0);
        chk("rst_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("rst_done", {31'd0, done_o[0]}, 32'd0);
        chk("rst_state", {30'd0, st0}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Four back-to-back beats from 0x10.
        rdy[0] = 1'b1;
        xc0.delete();
        busy_cnt[0] = 0;
        for (int k = 0; k < 4; k++) exp_q0.push_back(32'h10 + 32'(k));
        t0 = cyc;
        go(0, 16'd4, 32'h10);
        wait_idle(0, 50, 1'b0);
        tick();
        chk("t1_busy_cycles", 32'(busy_cnt[0]), 32'd5);
        chk("t1_beats", 32'(xc0.size()), 32'd4);
        if (xc0.size() == 4) begin
            chk("t1_first_cyc", 32'(xc0[0]), 32'(t0 + 1));
            chk("t1_last_cyc", 32'(xc0[3]), 32'(t0 + 4));
            chk("t1_done_cyc", 32'(last_done[0]), 32'(t0 + 5));
        end

        // Same burst under random backpressure.
        xc0.delete();
        for (int k = 0; k < 4; k++) exp_q0.push_back(32'h20 + 32'(k));
        rdy[0] = 1'b0;
        go(0, 16'd4, 32'h20);
        wait_idle(0, 300, 1'b1);
        chk("t2_beats", 32'(xc0.size()), 32'd4);
        rdy[0] = 1'b1;
        tick();

        // Gap of three on instance 1: beats four cycles apart.
        rdy[1] = 1'b1;
        xc1.delete();
        exp_q1.push_back(32'h100);
        exp_q1.push_back(32'h101);
        exp_q1.push_back(32'h102);
        t0 = cyc;
        go(1, 16'd3, 32'h100);
        wait_idle(1, 60, 1'b0);
        chk("t3_beats", 32'(xc1.size()), 32'd3);
        if (xc1.size() == 3) begin
            chk("t3_first_cyc", 32'(xc1[0]), 32'(t0 + 1));
            chk("t3_space1", 32'(xc1[1] - xc1[0]), 32'd4);
            chk("t3_space2", 32'(xc1[2] - xc1[1]), 32'd4);
            chk("t3_done_cyc", 32'(last_done[1]), 32'(xc1[2] + 1));
        end
        tick();

        // Data wraps past all-ones.
        exp_q0.push_back(32'hFFFF_FFFE);
        exp_q0.push_back(32'hFFFF_FFFF);
        exp_q0.push_back(32'h0000_0000);
        go(0, 16'd3, 32'hFFFF_FFFE);
        wait_idle(0, 50, 1'b0);
        chk("t4_data_after", data_o[0], 32'h0000_0001);
        tick();

        // Zero-length burst: busy and done together, then idle.
        xc0.delete();
        go(0, 16'd0, 32'h77);
        chk("t5_busy", {31'd0, busy_o[0]}, 32'd1);
        chk("t5_done", {31'd0, done_o[0]}, 32'd1);
        chk("t5_vld", {31'd0, see0.vld}, 32'd0);
        tick();
        chk("t5_busy_after", {31'd0, busy_o[0]}, 32'd0);
        chk("t5_done_after", {31'd0, done_o[0]}, 32'd0);
        chk("t5_no_beats", 32'(xc0.size()), 32'd0);

        // A start while busy is ignored.
        for (int k = 0; k < 4; k++) exp_q0.push_back(32'h40 + 32'(k));
        go(0, 16'd4, 32'h40);
        go(0, 16'd5, 32'h900);
        wait_idle(0, 50, 1'b0);
        chk("t5_ignored_beats", 32'(xc0.size()), 32'd4);
        chk("t5_data_after", data_o[0], 32'h44);
        tick();

        // Reset in the middle of a stalled beat.
        rdy[0] = 1'b0;
        d_before = last_done[0];
        go(0, 16'd4, 32'h50);
        tick();
        chk("t6_vld_before", {31'd0, see0.vld}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", {31'd0, see0.vld}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy_o[0]}, 32'd0);
        chk("t6_rst_data", see0.data, 32'd0);
        chk("t6_rst_done", {31'd0, done_o[0]}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", 32'(last_done[0]), 32'(d_before));

        // Fresh burst after reset.
        rdy[0] = 1'b1;
        xc0.delete();
        exp_q0.push_back(32'h60);
        exp_q0.push_back(32'h61);
        go(0, 16'd2, 32'h60);
        wait_idle(0, 50, 1'b0);
        chk("t6_beats", 32'(xc0.size()), 32'd2);
        if (xc0.size() == 2) chk("t6_done_cyc", 32'(last_done[0]), 32'(xc0[1] + 1));
        tick();

        chk("q0_empty", 32'(exp_q0.size()), 32'd0);
        chk("q1_empty", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
